// File: rtl/pair_triple_arbiter_pkg.sv
// Shared definitions for the pair/triple arbiter slice.
// VOTE_W is the width of one requester vote; IN*_OFS give the bit position
// of each detector input inside a vote, which is packed as {in2,in1,in0}.
package pair_triple_arbiter_pkg;

    localparam int VOTE_W  = 3;
    localparam int IN0_OFS = 0;
    localparam int IN1_OFS = 1;
    localparam int IN2_OFS = 2;

endpackage : pair_triple_arbiter_pkg

// File: rtl/PairTripleDetector_GL.sv
// Gate-level pair/triple (2-of-3 majority) detector.
// Ports:
//   in0, in1, in2 : the three vote bits
//   out           : 1 when at least two inputs are 1
// Built from AND/OR terms so that a known controlling value masks an X on
// another input (e.g. 1,1,X gives 1).
module PairTripleDetector_GL (
    input  logic in0,
    input  logic in1,
    input  logic in2,
    output logic out
);

    logic p01_s;
    logic p02_s;
    logic p12_s;

    assign p01_s = in0 & in1;
    assign p02_s = in0 & in2;
    assign p12_s = in1 & in2;
    assign out   = p01_s | p02_s | p12_s;

endmodule : PairTripleDetector_GL

// File: rtl/pair_triple_arbiter_rr_arbiter.sv
// NREQ-wide round-robin grant generator.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   en         : the grant is taken this cycle when a request is present
//   grant      : one-hot grant (before the enable is applied)
//   grant_idx  : index of the granted requester
//   grant_any  : at least one request present
// The search starts at ptr and wraps; ptr moves just past the winner only
// when the grant is actually taken, so a stalled grant keeps its priority.
module pair_triple_arbiter_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             en,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_next_s;
    logic [NREQ-1:0]  grant_s;
    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] cand_idx_s;
    logic             found_s;
    int               cand_s;

    // Priority search starting at ptr, wrapping modulo NREQ.
    always_comb begin
        grant_s    = '0;
        idx_s      = '0;
        found_s    = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = int'(ptr_r) + k;
            if (cand_s >= NREQ) begin
                cand_s = cand_s - NREQ;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IDX_W'(cand_s);
            if (!found_s && req[cand_idx_s]) begin
                found_s             = 1'b1;
                idx_s               = cand_idx_s;
                grant_s[cand_idx_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next pointer: one past the winner, wrapping at NREQ-1.
    always_comb begin
        ptr_next_s = ptr_r;
        if (en && found_s) begin
            if (idx_s == LAST_IDX) begin
                ptr_next_s = '0;
            end else begin
                ptr_next_s = idx_s + IDX_W'(1);
            end
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_next_s;
        end
    end

    assign grant     = grant_s;
    assign grant_idx = idx_s;
    assign grant_any = found_s;

endmodule : pair_triple_arbiter_rr_arbiter

// File: rtl/pair_triple_arbiter.sv
// Shares one 2-of-3 majority detector among NREQ requesters.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_val     : per-requester vote valid
//   req_rdy     : per-requester accept (at most one bit high)
//   req_bits    : requester i vote in [3i+2:3i], ordered {in2,in1,in0}
//   resp_val    : output buffer holds a result
//   resp_rdy    : consumer accepts the result
//   resp_out    : majority of the accepted vote
//   resp_id     : requester that produced resp_out
//   resp_count  : completed response transfers, wrapping
// A single-entry output buffer may be drained and refilled in the same cycle.
module pair_triple_arbiter
    import pair_triple_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_val,
    output logic [NREQ-1:0]        req_rdy,
    input  logic [VOTE_W*NREQ-1:0] req_bits,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic                   resp_out,
    output logic [IDX_W-1:0]       resp_id,
    output logic [CNT_W-1:0]       resp_count
);

    logic              can_accept_s;
    logic [NREQ-1:0]   grant_s;
    logic [IDX_W-1:0]  grant_idx_s;
    logic              grant_any_s;
    logic [VOTE_W-1:0] sel_vote_s;
    logic              maj_s;
    logic              req_fire_s;
    logic              resp_fire_s;

    logic              resp_val_r;
    logic              resp_out_r;
    logic [IDX_W-1:0]  resp_id_r;
    logic [CNT_W-1:0]  resp_count_r;

    assign can_accept_s = !resp_val_r || resp_rdy;
    assign resp_fire_s  = resp_val_r && resp_rdy;

    pair_triple_arbiter_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_val),
        .en        (can_accept_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // rst_n gates req_rdy because reset clears resp_val, which would
    // otherwise make can_accept true while the block is held in reset.
    assign req_rdy    = grant_s & {NREQ{can_accept_s && rst_n}};
    assign req_fire_s = grant_any_s && can_accept_s;

    // NREQ:1 mux selecting the granted requester's vote.
    always_comb begin
        sel_vote_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx_s == IDX_W'(i)) begin
                sel_vote_s = req_bits[VOTE_W*i +: VOTE_W];
            end else begin
                sel_vote_s = sel_vote_s;
            end
        end
    end

    PairTripleDetector_GL u_det (
        .in0 (sel_vote_s[IN0_OFS]),
        .in1 (sel_vote_s[IN1_OFS]),
        .in2 (sel_vote_s[IN2_OFS]),
        .out (maj_s)
    );

    // Output buffer: load on request fire, clear on a lone response fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_val_r <= 1'b0;
            resp_out_r <= 1'b0;
            resp_id_r  <= '0;
        end else if (req_fire_s) begin
            resp_val_r <= 1'b1;
            resp_out_r <= maj_s;
            resp_id_r  <= grant_idx_s;
        end else if (resp_fire_s) begin
            resp_val_r <= 1'b0;
        end else begin
            resp_val_r <= resp_val_r;
        end
    end

    // Completed-transfer counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_count_r <= '0;
        end else if (resp_fire_s) begin
            resp_count_r <= resp_count_r + CNT_W'(1);
        end else begin
            resp_count_r <= resp_count_r;
        end
    end

    assign resp_val   = resp_val_r;
    assign resp_out   = resp_out_r;
    assign resp_id    = resp_id_r;
    assign resp_count = resp_count_r;

endmodule : pair_triple_arbiter

// File: tb/tb_pair_triple_arbiter.sv
// Directed self-checking bench for pair_triple_arbiter (NREQ=4, CNT_W=8).
module tb_pair_triple_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [NREQ-1:0]  req_val;
    logic [NREQ-1:0]  req_rdy;
    logic [3*NREQ-1:0] req_bits;
    logic             resp_val;
    logic             resp_rdy;
    logic             resp_out;
    logic [1:0]       resp_id;
    logic [CNT_W-1:0] resp_count;

    int errors = 0;
    int checks = 0;

    pair_triple_arbiter #(
        .NREQ  (NREQ),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_bits   (req_bits),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_out   (resp_out),
        .resp_id    (resp_id),
        .resp_count (resp_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] maj_tbl;
    logic [3:0] rr_out;
    logic [1:0] drop_ids [6];
    logic       drop_outs [6];

    initial begin
        maj_tbl   = 8'b1110_1000;   // bit v = majority of vote v
        rr_out    = 4'b1100;        // outputs of req0..req3 for the rr vote set
        drop_ids  = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
        drop_outs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // ---- reset with all requesters valid ----
        rst_n    = 1'b0;
        req_val  = 4'b1111;
        req_bits = 12'b0;
        resp_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_rdy", 32'(req_rdy), 32'h0);
        check("rst_resp_val", 32'(resp_val), 32'h0);
        check("rst_resp_count", 32'(resp_count), 32'h0);
        check("rst_resp_id", 32'(resp_id), 32'h0);
        rst_n = 1'b1;
        #1;
        check("rel_req_rdy", 32'(req_rdy), 32'h1);
        step();
        check("rel_resp_val", 32'(resp_val), 32'h1);
        check("rel_resp_id", 32'(resp_id), 32'h0);
        check("rel_resp_out", 32'(resp_out), 32'h0);
        req_val = 4'b0000;
        step();
        check("rel_drain_val", 32'(resp_val), 32'h0);
        check("rel_drain_cnt", 32'(resp_count), 32'd1);

        // ---- requester 2, all eight votes ----
        req_val = 4'b0100;
        for (int v = 0; v < 8; v++) begin
            req_bits = 12'(v) << 6;
            #1;
            check("ex_req_rdy", 32'(req_rdy), 32'h4);
            step();
            check("ex_resp_val", 32'(resp_val), 32'h1);
            check("ex_resp_id", 32'(resp_id), 32'd2);
            check("ex_resp_out", 32'(resp_out), 32'(maj_tbl[v]));
        end
        req_val = 4'b0000;
        step();
        check("ex_count", 32'(resp_count), 32'd9);
        check("ex_val_clear", 32'(resp_val), 32'h0);

        // ---- reset mid-run restores ptr=0, then round-robin ----
        rst_n = 1'b0;
        #1;
        check("rr_rst_count", 32'(resp_count), 32'h0);
        rst_n    = 1'b1;
        req_val  = 4'b1111;
        req_bits = {3'b111, 3'b011, 3'b001, 3'b000};
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_id", 32'(resp_id), 32'(i % 4));
            check("rr_out", 32'(resp_out), 32'(rr_out[i % 4]));
        end
        req_val = 4'b1101;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_drop_id", 32'(resp_id), 32'(drop_ids[i]));
            check("rr_drop_out", 32'(resp_out), 32'(drop_outs[i]));
        end
        req_val = 4'b0000;
        step();
        check("rr_count", 32'(resp_count), 32'd14);

        // ---- backpressure ----
        req_val  = 4'b0010;
        req_bits = 12'b000_000_011_000;
        step();
        check("bp_fill_id", 32'(resp_id), 32'd1);
        check("bp_fill_out", 32'(resp_out), 32'd1);
        resp_rdy = 1'b0;
        req_val  = 4'b1111;
        req_bits = 12'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_req_rdy", 32'(req_rdy), 32'h0);
            step();
            check("bp_val", 32'(resp_val), 32'h1);
            check("bp_out", 32'(resp_out), 32'h1);
            check("bp_id", 32'(resp_id), 32'd1);
        end
        resp_rdy = 1'b1;
        #1;
        check("bp_ptr_frozen", 32'(req_rdy), 32'h4);
        step();
        check("bp_refill_val", 32'(resp_val), 32'h1);
        check("bp_refill_id", 32'(resp_id), 32'd2);
        check("bp_refill_out", 32'(resp_out), 32'h0);
        check("bp_count", 32'(resp_count), 32'd15);
        req_val = 4'b0000;
        step();
        check("bp_drain_count", 32'(resp_count), 32'd16);

        // ---- counter wrap, then asynchronous reset with a pending response ----
        req_val  = 4'b1000;
        req_bits = 12'b111_000_000_000;
        repeat (240) step();
        check("wrap_255", 32'(resp_count), 32'd255);
        step();
        check("wrap_0", 32'(resp_count), 32'd0);
        check("wrap_val", 32'(resp_val), 32'h1);
        check("wrap_id", 32'(resp_id), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_val", 32'(resp_val), 32'h0);
        check("arst_out", 32'(resp_out), 32'h0);
        check("arst_id", 32'(resp_id), 32'h0);
        check("arst_req_rdy", 32'(req_rdy), 32'h0);
        step();
        rst_n = 1'b1;

        // ---- X on one vote bit is masked by two ones ----
        req_val  = 4'b0001;
        req_bits = {9'b0, 1'bx, 2'b11};
        step();
        check("x_mask_out", 32'(resp_out), 32'h1);
        check("x_mask_id", 32'(resp_id), 32'h0);
        req_val = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pair_triple_arbiter
